// File: rtl/mem_d1_stream_reader.sv
// rtl/mem_d1_stream_reader.sv - streams words 0..n-1 of a std_mem_d1 out over a valid/ready port
// A one-word output register with skid-free refill keeps throughput at one word per cycle.
module mem_d1_stream_reader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   count,
  output logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    read_data,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  output logic                done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0] ONE    = (IDX_SIZE+1)'(1);

  logic [1:0]        state_q, state_d;
  logic [IDX_SIZE:0] n_q, n_d;
  logic [IDX_SIZE:0] issued_q, issued_d;
  logic [IDX_SIZE:0] accepted_q, accepted_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;

  logic [IDX_SIZE:0] count_clamped;
  logic              load;
  logic              xfer;

  always_comb begin
    count_clamped = (count > SIZE_W) ? SIZE_W : count;
    // Refill the output register whenever it is empty or being drained this cycle.
    load = (state_q == ST_RUN) && (issued_q < n_q) && (!out_valid_q || out_ready);
    xfer = (state_q == ST_RUN) && out_valid_q && out_ready;

    state_d     = state_q;
    n_d         = n_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          n_d        = count_clamped;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (count_clamped != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (load) begin
          out_data_d = read_data;
          issued_d   = issued_q + ONE;
        end
        if (load) begin
          out_valid_d = 1'b1;
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
        if (xfer) begin
          accepted_d = accepted_q + ONE;
          if (accepted_q + ONE == n_q) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign addr0     = (state_q == ST_RUN) ? issued_q[IDX_SIZE-1:0] : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_mem_d1_stream_reader.sv
// tb/tb_mem_d1_stream_reader.sv - scoreboard bench for mem_d1_stream_reader
// Memory model holds 10+i at address i; expected words are queued when go is driven.
module tb_mem_d1_stream_reader;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int IDX_SIZE = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                go;
  logic [IDX_SIZE:0]   count;
  logic [IDX_SIZE-1:0] addr0;
  logic [WIDTH-1:0]    read_data;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic                out_ready;
  logic                done;

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] sb [$];
  int vectors     = 0;
  int miscompares = 0;

  mem_d1_stream_reader #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
    .clk(clk), .reset(reset), .go(go), .count(count), .addr0(addr0),
    .read_data(read_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;
  assign read_data = mem[addr0];

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_w;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra: got word %0d, required no transfer", out_data);
      end else begin
        exp_w = sb.pop_front();
        if (out_data !== exp_w) begin
          miscompares++;
          $display("FAIL sb_word: got %0d, required %0d", out_data, exp_w);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int cnt);
    int n;
    n = (cnt > SIZE) ? SIZE : cnt;
    for (int i = 0; i < n; i++) sb.push_back(WIDTH'(10 + i));
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; count = '0; out_ready = 1'b0;
    cycle();
    cycle();
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || addr0 !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b done=%b addr0=%0d data=%0d, required 0 0 0 0",
               out_valid, done, addr0, out_data);
    end
    reset = 1'b0;
    cycle();
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || addr0 !== '0) begin
      miscompares++;
      $display("FAIL idle_hold: got valid=%b done=%b addr0=%0d, required 0 0 0", out_valid, done, addr0);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    go = 1'b1; count = 5'd4; push_expected(4);
    cycle();
    go = 1'b0; count = 5'd1;
    vectors++;
    if (out_valid !== 1'b0 || addr0 !== 4'd0) begin
      miscompares++;
      $display("FAIL basic_c1: got valid=%b addr0=%0d, required 0 0", out_valid, addr0);
    end
    for (int c = 2; c <= 5; c++) begin
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(10 + c - 2) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_word c%0d: got valid=%b data=%0d done=%b, required 1 %0d 0",
                 c, out_valid, out_data, done, 10 + c - 2);
      end
    end
    cycle();
    vectors++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done c6: got done=%b valid=%b, required 1 0", done, out_valid);
    end
    cycle();
    vectors++;
    if (done !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL basic_end: got done=%b pending=%0d, required 0 0", done, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0, last_xfer = -1, done_cycle = -1;
    logic stalled = 1'b0;
    logic [WIDTH-1:0] held = '0;
    out_ready = 1'b0;
    go = 1'b1; count = 5'd3; push_expected(3);
    cycle();
    go = 1'b0;
    for (int c = 1; c < 40; c++) begin
      out_ready = ~out_ready;
      if (out_valid === 1'b1) begin
        if (stalled) begin
          vectors++;
          if (out_data !== held) begin
            miscompares++;
            $display("FAIL bp_stable c%0d: got %0d, required %0d", c, out_data, held);
          end
        end
        stalled = !out_ready;
        held = out_data;
        if (out_ready) begin
          xfers++;
          last_xfer = c;
        end
      end else begin
        stalled = 1'b0;
      end
      if (done === 1'b1) begin
        done_cycle = c;
        break;
      end
      cycle();
    end
    vectors++;
    if (xfers != 3 || done_cycle < 0 || done_cycle != last_xfer + 1) begin
      miscompares++;
      $display("FAIL bp_done: got xfers=%0d done_cycle=%0d last_xfer=%0d, required 3 transfers and done one cycle after",
               xfers, done_cycle, last_xfer);
    end
    out_ready = 1'b1;
    cycle();
    vectors++;
    if (done !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_end: got done=%b pending=%0d, required 0 0", done, sb.size());
    end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    go = 1'b1; count = 5'd0;
    cycle();
    go = 1'b0;
    vectors++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done c1: got done=%b valid=%b, required 1 0", done, out_valid);
    end
    for (int c = 2; c <= 4; c++) begin
      cycle();
      vectors++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_after c%0d: got done=%b valid=%b, required 0 0", c, done, out_valid);
      end
    end
  endtask

  task automatic test_clamp();
    int xfers = 0, dones = 0, done_cycle = -1;
    out_ready = 1'b1;
    go = 1'b1; count = 5'd20; push_expected(20);
    cycle();
    go = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (out_valid === 1'b1) xfers++;
      if (done === 1'b1) begin
        dones++;
        done_cycle = c;
      end
      cycle();
    end
    vectors++;
    if (xfers != 16 || dones != 1 || done_cycle != 18 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL clamp: got xfers=%0d dones=%0d done_cycle=%0d pending=%0d, required 16 1 18 0",
               xfers, dones, done_cycle, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    go = 1'b1; count = 5'd8; push_expected(8);
    cycle();
    go = 1'b0;
    cycle();
    cycle();
    cycle();
    reset = 1'b1; go = 1'b1; count = 5'd5;
    cycle();
    reset = 1'b0; go = 1'b0;
    sb.delete();
    vectors++;
    if (out_valid !== 1'b0 || addr0 !== 4'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: got valid=%b addr0=%0d done=%b, required 0 0 0", out_valid, addr0, done);
    end
    for (int c = 6; c <= 8; c++) begin
      cycle();
      vectors++;
      if (out_valid !== 1'b0 || addr0 !== 4'd0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_idle c%0d: got valid=%b addr0=%0d done=%b, required 0 0 0", c, out_valid, addr0, done);
      end
    end
    go = 1'b1; count = 5'd2; push_expected(2);
    cycle();
    go = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (done !== (c == 4) || out_valid !== (c == 2 || c == 3)) begin
        miscompares++;
        $display("FAIL rst_rerun c%0d: got done=%b valid=%b", c, done, out_valid);
      end
      cycle();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rst_rerun_pending: got %0d, required 0", sb.size());
    end
  endtask

  task automatic test_go_held();
    out_ready = 1'b1;
    go = 1'b1; count = 5'd2;
    push_expected(2); push_expected(2);
    cycle();
    for (int c = 1; c <= 10; c++) begin
      if (c == 6) go = 1'b0;
      vectors++;
      if (done !== (c == 4 || c == 9) || out_valid !== (c == 2 || c == 3 || c == 7 || c == 8)) begin
        miscompares++;
        $display("FAIL go_held c%0d: got done=%b valid=%b", c, done, out_valid);
      end
      cycle();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL go_held_pending: got %0d, required 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(10 + i);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_clamp();
    test_reset_mid();
    test_go_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_d1_stream_reader.md
MEM_D1_STREAM_READER -- requirements
Module: mem_d1_stream_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width; SHALL match the attached std_mem_d1 WIDTH.
REQ-002 Parameter SIZE, default 16, number of words in the attached memory.
REQ-003 Parameter IDX_SIZE, default 4, address width; SHALL satisfy 2**IDX_SIZE >= SIZE.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 go  input  1  start request; sampled only in IDLE.
REQ-007 count  input  IDX_SIZE+1  number of words to stream, starting at address 0; sampled with go.
REQ-008 addr0  output  IDX_SIZE  read address to the memory's addr0.
REQ-009 read_data  input  WIDTH  combinational read data from the memory for the current addr0.
REQ-010 out_valid  output  1  out_data holds an unconsumed word.
REQ-011 out_data  output  WIDTH  streamed word.
REQ-012 out_ready  input  1  consumer accepts the word; transfer when out_valid && out_ready.
REQ-013 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, FIN.
REQ-015 IDLE: go=1 SHALL latch n = min(count, SIZE), clear issued and accepted counters (IDX_SIZE+1 bits each), and go to RUN if n>0, else go to FIN.
REQ-016 IDLE: go=0 SHALL hold state; out_valid=0, done=0, addr0=0.
REQ-017 addr0 SHALL equal issued[IDX_SIZE-1:0] in RUN; after issued reaches SIZE the value wraps and is don't-care.
REQ-018 Load condition in RUN: issued < n and (!out_valid or out_ready).
REQ-019 On load, out_data SHALL capture read_data, out_valid SHALL be 1 the next cycle, and issued SHALL increment.
REQ-020 On transfer without load, out_valid SHALL go to 0 the next cycle; on transfer with load, out_valid SHALL stay 1 (full throughput, 1 word/cycle).
REQ-021 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-022 Each transfer SHALL increment accepted; the transfer that makes accepted == n SHALL move the FSM to FIN.
REQ-023 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE; out_valid=0 in FIN.
REQ-024 Latency: with go at cycle 0 and out_ready held at 1, the word at address i SHALL be valid in cycle 2+i; done SHALL be high in cycle n+2.
REQ-025 go asserted in RUN or FIN SHALL be ignored; count changes after the go sample SHALL have no effect.
REQ-026 count > SIZE SHALL be clamped to SIZE; count = 0 SHALL give done in the cycle after go with no transfers.
REQ-027 Words SHALL be delivered in ascending address order; none dropped or duplicated.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, out_valid=0, done=0, out_data=0, addr0=0, counters=0, regardless of state.
REQ-029 Reset mid-stream SHALL abandon the transfer; no done pulse SHALL follow.
REQ-030 Reset SHALL take priority over go in the same cycle.

Verification
REQ-031 Memory holds 10,11,...,25 (SIZE=16); go with count=4, out_ready=1 -> out_data 10,11,12,13 in cycles 2-5; done=1 in cycle 6 only.
REQ-032 count=3, out_ready toggles 0,1,0,1,... -> exactly 3 transfers (10,11,12), out_data stable while stalled, done one cycle after the third transfer.
REQ-033 count=0 -> done=1 in cycle 1, out_valid never asserted.
REQ-034 count=20 with SIZE=16 -> exactly 16 transfers (10..25), addr0 never issues an address above 15, single done pulse.
REQ-035 reset asserted after 2 of 8 transfers -> next cycle out_valid=0, addr0=0, state IDLE, no done; a new go with count=2 then streams 10,11.
REQ-036 go held high through RUN and FIN (count=2) -> exactly one run of 2 words and one done, then a new run starts from the next IDLE cycle.
